chaos_code_stream: RTL and testbench

Parametrised fixed-point successor to the float-IP chaos code generator. It integrates the same 4-D hyperchaotic system (x, y, z, w) with one Euler step per iteration, using in-fabric signed Q-format arithmetic. It runs a programmable warm-up after every seed load. It emits one OUT_W-bit key per state variable per iteration over a valid/ready stream, in single-step or free-run mode. It sits between the key-setup logic (seed/scale source) and the stream cipher mixer.

---
 rtl/chaos_code_stream.sv | 155 +++++++++++++++
 tb/tb_chaos_code_stream.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaos_code_stream.sv
// Fixed-point 4-D hyperchaotic key generator: one Euler step per three-cycle
// iteration, saturating Q arithmetic, programmable warm-up, valid/ready key output.
module chaos_code_stream #(
  parameter int W      = 48,
  parameter int F      = 24,
  parameter int OUT_W  = 8,
  parameter int WARMUP = 64,
  parameter logic signed [W-1:0] A      = 48'sd335544320,
  parameter logic signed [W-1:0] B      = 48'sd8388608,
  parameter logic signed [W-1:0] C      = 48'sd114085069,
  parameter logic signed [W-1:0] D      = 48'sd134217728,
  parameter logic signed [W-1:0] E      = 48'sd8388608,
  parameter logic signed [W-1:0] T      = 48'sd167772,
  parameter logic signed [W-1:0] SEED0  = 48'sd1677722,
  parameter logic signed [W-1:0] SCALE0 = 48'sd16777216000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LOAD,
  input  logic [4*W-1:0]     SEED,
  input  logic [W-1:0]       SCALE,
  input  logic               STEP,
  input  logic               RUN,
  output logic               BUSY,
  output logic               KEY_VALID,
  input  logic               KEY_READY,
  output logic [4*OUT_W-1:0] KEY
);

  // Stream handshake: a word transfers on any rising edge where KEY_VALID and
  // KEY_READY are both high; KEY is held stable while KEY_VALID=1 and KEY_READY=0.

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_KEY} state_t;
  state_t state;

  logic signed [W-1:0] x, y, z, w, scale;
  logic signed [W-1:0] pa, pyz, pb, pc, pxz, pe, pxx, pd;
  logic signed [W-1:0] tx, ty, tz, tw;
  logic [15:0]         wcnt;
  logic                key_valid;
  logic [4*OUT_W-1:0]  key;
  logic                handshake, out_free;

  function automatic logic signed [W-1:0] sat_n(input logic signed [W+1:0] v);
    if (v[W+1:W-1] == {3{v[W+1]}}) return W'(v);
    return v[W+1] ? MINV : MAXV;
  endfunction

  function automatic logic signed [W-1:0] sat_2w(input logic signed [2*W-1:0] v);
    if (v[2*W-1:W-1] == {(W+1){v[2*W-1]}}) return W'(v);
    return v[2*W-1] ? MINV : MAXV;
  endfunction

  function automatic logic signed [W-1:0] sadd(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic [W+1:0] s;
    s = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b};
    return sat_n(s);
  endfunction

  function automatic logic signed [W-1:0] ssub(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic [W+1:0] s;
    s = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b};
    return sat_n(s);
  endfunction

  // Sign-extended operands make the 2W-bit unsigned product bit-identical to the signed one.
  function automatic logic signed [W-1:0] mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    return sat_2w(p >>> F);
  endfunction

  function automatic logic [OUT_W-1:0] key_bits(input logic signed [W-1:0] v, input logic signed [W-1:0] s);
    logic signed [W-1:0] m;
    m = mul(v, s);
    return OUT_W'(m >>> F);
  endfunction

  assign handshake = key_valid & KEY_READY;
  assign out_free  = ~key_valid | KEY_READY;
  assign BUSY      = (state != S_IDLE);
  assign KEY_VALID = key_valid;
  assign KEY       = key;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      x         <= SEED0;
      y         <= SEED0;
      z         <= SEED0;
      w         <= SEED0;
      scale     <= SCALE0;
      wcnt      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
    end else if (LOAD) begin
      x         <= SEED[4*W-1:3*W];
      y         <= SEED[3*W-1:2*W];
      z         <= SEED[2*W-1:W];
      w         <= SEED[W-1:0];
      scale     <= SCALE;
      key_valid <= 1'b0;
      wcnt      <= 16'(WARMUP);
      state     <= (WARMUP == 0) ? S_IDLE : S_P1;
    end else begin
      if (handshake) key_valid <= 1'b0;
      case (state)
        S_IDLE: if ((STEP | RUN) && out_free) state <= S_P1;
        S_P1: begin
          pa    <= mul(A, ssub(y, x));
          pyz   <= mul(y, z);
          pb    <= mul(B, x);
          pc    <= mul(C, y);
          pxz   <= mul(x, z);
          pe    <= mul(E, w);
          pxx   <= mul(x, x);
          pd    <= mul(D, z);
          state <= S_P2;
        end
        S_P2: begin
          tx    <= mul(T, sadd(sadd(pa, pyz), w));
          ty    <= mul(T, ssub(ssub(sadd(pb, pc), pxz), pe));
          tz    <= mul(T, ssub(pxx, pd));
          tw    <= mul(T, ssub(x, w));
          state <= S_P3;
        end
        S_P3: begin
          x <= sadd(x, tx);
          y <= sadd(y, ty);
          z <= sadd(z, tz);
          w <= sadd(w, tw);
          if (wcnt != 16'd0) begin
            wcnt  <= wcnt - 16'd1;
            state <= S_P1;
          end else begin
            state <= S_KEY;
          end
        end
        S_KEY: begin
          // Stall here under back-pressure; state variables are untouched meanwhile.
          if (out_free) begin
            key       <= {key_bits(x, scale), key_bits(y, scale), key_bits(z, scale), key_bits(w, scale)};
            key_valid <= 1'b1;
            state     <= RUN ? S_P1 : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_code_stream.sv
// Bench for chaos_code_stream: Q-format reference model feeds an expected-key queue,
// a negedge monitor pops and compares every accepted word.
module tb_chaos_code_stream;

  localparam int W = 48, F = 24, OUT_W = 8, WARMUP = 64;
  typedef logic signed [127:0] big_t;
  localparam big_t MAXB = (big_t'(1) <<< (W-1)) - 1;
  localparam big_t MINB = -(big_t'(1) <<< (W-1));
  localparam big_t CA = 335544320, CB = 8388608, CC = 114085069;
  localparam big_t CD = 134217728, CE = 8388608, CT = 167772;
  localparam big_t Q01 = 1677722, QSC0 = 64'sd16777216000;

  logic               CLK = 1'b0;
  logic               RESET, LOAD, STEP, RUN, KEY_READY;
  logic [4*W-1:0]     SEED;
  logic [W-1:0]       SCALE;
  logic               BUSY, KEY_VALID;
  logic [4*OUT_W-1:0] KEY;

  chaos_code_stream dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .SEED(SEED), .SCALE(SCALE),
    .STEP(STEP), .RUN(RUN), .BUSY(BUSY), .KEY_VALID(KEY_VALID),
    .KEY_READY(KEY_READY), .KEY(KEY)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [4*OUT_W-1:0] exp_q[$];
  int pushed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain big-integer arithmetic clamped to the W-bit range
  big_t mx, my, mz, mw, msc;
  big_t sx, sy, sz, sw;

  function automatic big_t clampv(input big_t v);
    if (v > MAXB) return MAXB;
    if (v < MINB) return MINB;
    return v;
  endfunction
  function automatic big_t qmul(input big_t a, input big_t b);
    return clampv((a * b) >>> F);
  endfunction
  function automatic big_t qadd(input big_t a, input big_t b);
    return clampv(a + b);
  endfunction

  task automatic model_iter();
    big_t pa, pyz, pb, pc, pxz, pe, pxx, pd, dx, dy, dz, dw;
    pa  = qmul(CA, qadd(my, -mx));
    pyz = qmul(my, mz);
    pb  = qmul(CB, mx);
    pc  = qmul(CC, my);
    pxz = qmul(mx, mz);
    pe  = qmul(CE, mw);
    pxx = qmul(mx, mx);
    pd  = qmul(CD, mz);
    dx  = qmul(CT, qadd(qadd(pa, pyz), mw));
    dy  = qmul(CT, qadd(qadd(qadd(pb, pc), -pxz), -pe));
    dz  = qmul(CT, qadd(pxx, -pd));
    dw  = qmul(CT, qadd(mx, -mw));
    mx = qadd(mx, dx);
    my = qadd(my, dy);
    mz = qadd(mz, dz);
    mw = qadd(mw, dw);
  endtask

  function automatic logic [7:0] kbyte(input big_t v, input big_t s);
    big_t m;
    m = qmul(v, s);
    return m[F+7:F];
  endfunction

  function automatic logic [31:0] model_key();
    return {kbyte(mx, msc), kbyte(my, msc), kbyte(mz, msc), kbyte(mw, msc)};
  endfunction

  task automatic model_load(input big_t v, input big_t s);
    mx = v; my = v; mz = v; mw = v; msc = s;
  endtask

  // Push the next n keyed iterations as lookahead; end_segment rewinds to what was consumed.
  task automatic begin_segment(input int n);
    sx = mx; sy = my; sz = mz; sw = mw;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      model_iter();
      exp_q.push_back(model_key());
    end
    pushed = n;
  endtask

  task automatic end_segment(output int consumed);
    consumed = pushed - exp_q.size();
    mx = sx; my = sy; mz = sz; mw = sw;
    for (int i = 0; i < consumed; i++) model_iter();
    exp_q.delete();
  endtask

  // Monitor: compare every accepted word; also check KEY holds under back-pressure
  logic last_valid = 1'b0, last_ready = 1'b0, last_ctl = 1'b1;
  logic [31:0] last_key = '0;
  always @(negedge CLK) begin
    if (last_valid && !last_ready && !last_ctl) begin
      check("hold_valid", {63'd0, KEY_VALID}, 64'd1);
      check("hold_key", {32'd0, KEY}, {32'd0, last_key});
    end
    if (!RESET && KEY_VALID && KEY_READY) begin
      if (exp_q.size() == 0) check("unexpected_key", {32'd0, KEY}, 64'd0 - 64'd1);
      else check("key_word", {32'd0, KEY}, {32'd0, exp_q.pop_front()});
    end
    last_valid = KEY_VALID;
    last_ready = KEY_READY;
    last_ctl   = RESET | LOAD;
    last_key   = KEY;
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    STEP = 0; RUN = 0; KEY_READY = 1;
    n = 0;
    while ((BUSY || KEY_VALID) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, {63'd0, (BUSY || KEY_VALID)}, 64'd0);
    tick();
  endtask

  task automatic do_load(input big_t v, input big_t s, input logic with_step);
    SEED = {W'(v), W'(v), W'(v), W'(v)};
    SCALE = W'(s);
    LOAD = 1; STEP = with_step;
    tick();
    LOAD = 0; STEP = 0;
    exp_q.delete();
    model_load(v, s);
    for (int i = 0; i < WARMUP; i++) model_iter();
  endtask

  int consumed, last_v, bad_gap, nv;
  logic ok_busy, ok_idle;
  logic [31:0] held;
  big_t rscale;

  initial begin
    RESET = 1; LOAD = 0; STEP = 0; RUN = 0; KEY_READY = 0; SEED = '0; SCALE = '0;
    repeat (3) tick();
    check("reset_key", {32'd0, KEY}, 64'd0);
    check("reset_valid", {63'd0, KEY_VALID}, 64'd0);
    check("reset_busy", {63'd0, BUSY}, 64'd0);
    RESET = 0;
    tick();
    model_load(Q01, QSC0);

    // Single step: 5-cycle latency and known first key
    begin_segment(4);
    STEP = 1;
    tick();
    STEP = 0;
    check("step_busy", {63'd0, BUSY}, 64'd1);
    ok_idle = 1;
    for (int i = 0; i < 4; i++) begin
      if (KEY_VALID) ok_idle = 0;
      tick();
    end
    check("step_latency_low", {63'd0, ok_idle}, 64'd1);
    check("step_latency_valid", {63'd0, KEY_VALID}, 64'd1);
    check("step_first_key", {32'd0, KEY}, 64'h656A5C64);
    check("step_idle_after_key", {63'd0, BUSY}, 64'd0);
    drain("step");
    end_segment(consumed);
    check("step_count", 64'(consumed), 64'd1);

    // Free-run: one word every 4 cycles
    begin_segment(64);
    RUN = 1; KEY_READY = 1;
    last_v = -1; bad_gap = 0; nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (KEY_VALID) begin
        if (last_v >= 0 && c - last_v != 4) bad_gap++;
        last_v = c;
        nv++;
      end
      tick();
    end
    check("freerun_gap", 64'(bad_gap), 64'd0);
    check("freerun_enough", {63'd0, nv >= 8}, 64'd1);
    drain("freerun");
    end_segment(consumed);
    check("freerun_count", {63'd0, consumed >= 10}, 64'd1);

    // Back-pressure stall then random ready
    begin_segment(64);
    RUN = 1; KEY_READY = 0;
    repeat (20) tick();
    check("bp_busy", {63'd0, BUSY}, 64'd1);
    check("bp_valid", {63'd0, KEY_VALID}, 64'd1);
    held = KEY;
    check("bp_held_is_head", {32'd0, held}, {32'd0, exp_q[0]});
    for (int c = 0; c < 60; c++) begin
      KEY_READY = 1'($urandom_range(0, 1));
      tick();
    end
    drain("bp");
    end_segment(consumed);

    // Random RUN/STEP/READY mix
    begin_segment(64);
    for (int c = 0; c < 150; c++) begin
      if ($urandom_range(0, 9) == 0) RUN = ~RUN;
      STEP = ($urandom_range(0, 5) == 0);
      KEY_READY = 1'($urandom_range(0, 1));
      tick();
    end
    drain("random");
    end_segment(consumed);

    // LOAD mid-run: pending word dropped, warm-up of 64 iterations
    begin_segment(64);
    RUN = 1;
    for (int c = 0; c < 30; c++) begin
      KEY_READY = 1'($urandom_range(0, 1));
      tick();
    end
    rscale = big_t'($urandom_range(1, 65535)) <<< 12;
    do_load(Q01, rscale, 1'b0);
    begin_segment(64);
    KEY_READY = 1;
    check("load_valid_drop", {63'd0, KEY_VALID}, 64'd0);
    ok_busy = 1; ok_idle = 1;
    for (int c = 0; c < 196; c++) begin
      if (!BUSY) ok_busy = 0;
      if (KEY_VALID) ok_idle = 0;
      tick();
    end
    check("load_warm_busy", {63'd0, ok_busy}, 64'd1);
    check("load_warm_novalid", {63'd0, ok_idle}, 64'd1);
    check("load_first_valid", {63'd0, KEY_VALID}, 64'd1);
    check("load_first_key", {32'd0, KEY}, {32'd0, exp_q[0]});
    repeat (20) tick();
    drain("load");
    end_segment(consumed);

    // Saturation: all state at max, scale 1.0
    do_load(MAXB, big_t'(1) <<< F, 1'b0);
    begin_segment(64);
    RUN = 1; KEY_READY = 1;
    repeat (240) tick();
    drain("sat");
    end_segment(consumed);
    check("sat_count", {63'd0, consumed >= 10}, 64'd1);

    // LOAD and STEP together: STEP dropped, only the post-warm-up word appears
    do_load(Q01, QSC0, 1'b1);
    begin_segment(4);
    drain("loadstep");
    end_segment(consumed);
    check("loadstep_count", 64'(consumed), 64'd1);

    // RESET during P2 restores SEED0/SCALE0
    begin_segment(4);
    KEY_READY = 0;
    STEP = 1;
    tick();
    STEP = 0;
    tick();
    RESET = 1;
    tick();
    RESET = 0;
    exp_q.delete();
    check("p2reset_valid", {63'd0, KEY_VALID}, 64'd0);
    check("p2reset_busy", {63'd0, BUSY}, 64'd0);
    check("p2reset_key", {32'd0, KEY}, 64'd0);
    model_load(Q01, QSC0);
    begin_segment(4);
    STEP = 1;
    tick();
    STEP = 0;
    repeat (4) tick();
    check("p2reset_seed_key", {32'd0, KEY}, 64'h656A5C64);
    drain("p2reset");
    end_segment(consumed);
    check("p2reset_count", 64'(consumed), 64'd1);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
